// File: rtl/spongent_stream_ctrl_if.sv
// Handshake bundle between the stream controller, its message/digest streams
// and the SPONGENT core. master = controller side, slave = surrounding logic.
interface spongent_stream_ctrl_if #(
  parameter int RATE = 8
);
  logic            msg_valid;
  logic            msg_ready;
  logic [RATE-1:0] msg_data;
  logic            msg_last;
  logic            dig_valid;
  logic            dig_ready;
  logic [RATE-1:0] dig_data;
  logic            dig_last;
  logic            busy;
  logic            core_reset;
  logic            core_start_continue;
  logic            core_msg_data_available;
  logic [RATE-1:0] core_data_in;
  logic            core_busy;
  logic [RATE-1:0] core_data_out;

  modport master (
    input  msg_valid, msg_data, msg_last, dig_ready, core_busy, core_data_out,
    output msg_ready, dig_valid, dig_data, dig_last, busy,
           core_reset, core_start_continue, core_msg_data_available, core_data_in
  );

  modport slave (
    output msg_valid, msg_data, msg_last, dig_ready, core_busy, core_data_out,
    input  msg_ready, dig_valid, dig_data, dig_last, busy,
           core_reset, core_start_continue, core_msg_data_available, core_data_in
  );
endinterface

// File: rtl/spongent_stream_ctrl.sv
// Drives the SPONGENT core through absorb, padding and squeeze invocations,
// taking message blocks from one stream and emitting digest beats on another.
module spongent_stream_ctrl #(
  parameter int RATE        = 8,
  parameter int DIGEST_BITS = 128
) (
  input  logic                   clk,
  input  logic                   reset,
  spongent_stream_ctrl_if.master bus
);
  localparam int N = DIGEST_BITS / RATE;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [RATE-1:0] PAD_BLK = {1'b1, {(RATE-1){1'b0}}};

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_ABS_GO, S_ABS_WAIT, S_PAD_GO, S_PAD_WAIT,
    S_OUT, S_SQ_GO, S_SQ_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [RATE-1:0]   blk_q, blk_d;
  logic [RATE-1:0]   dig_q, dig_d;
  logic              last_q, last_d;
  logic              in_msg_q, in_msg_d;
  logic              first_q, first_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              core_done;

  // The core may raise busy one cycle late, so the first wait cycle never completes.
  assign core_done = !first_q && !bus.core_busy;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      blk_q    <= '0;
      dig_q    <= '0;
      last_q   <= 1'b0;
      in_msg_q <= 1'b0;
      first_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      blk_q    <= blk_d;
      dig_q    <= dig_d;
      last_q   <= last_d;
      in_msg_q <= in_msg_d;
      first_q  <= first_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    blk_d    = blk_q;
    dig_d    = dig_q;
    last_d   = last_q;
    in_msg_d = in_msg_q;
    first_d  = 1'b0;
    cnt_d    = cnt_q;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        if (bus.msg_valid) begin
          blk_d    = bus.msg_data;
          last_d   = bus.msg_last;
          in_msg_d = 1'b1;
          state_d  = S_ABS_GO;
        end
      end
      S_ABS_GO: begin
        first_d = 1'b1;
        state_d = S_ABS_WAIT;
      end
      S_ABS_WAIT: begin
        if (core_done) state_d = last_q ? S_PAD_GO : S_LOAD;
      end
      S_PAD_GO: begin
        first_d = 1'b1;
        state_d = S_PAD_WAIT;
      end
      S_PAD_WAIT: begin
        if (core_done) begin
          dig_d   = bus.core_data_out;
          cnt_d   = '0;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.dig_ready) begin
          if (cnt_q == CNT_LAST) begin
            in_msg_d = 1'b0;
            state_d  = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            state_d = S_SQ_GO;
          end
        end
      end
      S_SQ_GO: begin
        first_d = 1'b1;
        state_d = S_SQ_WAIT;
      end
      S_SQ_WAIT: begin
        if (core_done) begin
          dig_d   = bus.core_data_out;
          state_d = S_OUT;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.msg_ready               = (state_q == S_LOAD);
  assign bus.dig_valid               = (state_q == S_OUT);
  assign bus.dig_last                = (state_q == S_OUT) && (cnt_q == CNT_LAST);
  assign bus.dig_data                = dig_q;
  assign bus.busy                    = in_msg_q || !(state_q inside {S_IDLE, S_LOAD});
  assign bus.core_reset              = (state_q == S_IDLE);
  assign bus.core_start_continue     = state_q inside {S_ABS_GO, S_PAD_GO, S_SQ_GO};
  assign bus.core_msg_data_available = state_q inside {S_ABS_GO, S_PAD_GO};
  assign bus.core_data_in            = (state_q == S_ABS_GO) ? blk_q :
                                       (state_q == S_PAD_GO) ? PAD_BLK : '0;
endmodule

// File: doc/spongent_stream_ctrl.md
Name: spongent_stream_ctrl

Overview:
- Initiator/driver for the SPONGENT hash core's start_continue / msg_data_available / busy handshake.
- Accepts a message as a stream of RATE-bit blocks (valid/ready, last flag) and feeds each block to the core for absorption.
- Appends the sponge padding block, then issues squeeze requests and streams the digest out as RATE-bit beats (valid/ready, last flag).
- Sits between the bus-side hashing unit and the core; the core itself is unchanged.

Parameters:
- RATE, 8, block width on the message stream, the core data ports and the digest stream.
- DIGEST_BITS, 128, digest length. Must be a multiple of RATE. N = DIGEST_BITS/RATE digest beats.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- msg_valid  in  1  message block valid
- msg_ready  out  1  controller accepts block
- msg_data  in  RATE  message block
- msg_last  in  1  final message block (sampled with msg_data)
- dig_valid  out  1  digest beat valid
- dig_ready  in  1  digest sink accepts beat
- dig_data  out  RATE  digest beat
- dig_last  out  1  final digest beat
- busy  out  1  message or digest in progress
- core_reset  out  1  reset to core
- core_start_continue  out  1  core start pulse
- core_msg_data_available  out  1  1 = absorb, 0 = squeeze
- core_data_in  out  RATE  block to core
- core_busy  in  1  core busy
- core_data_out  in  RATE  core rate output

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- All outputs are Moore decodes of registered state/data.
- Reset values:
  - State = IDLE; core_reset = 1.
  - msg_ready, dig_valid, dig_last, busy, core_start_continue and core_msg_data_available = 0.
  - dig_data = 0; core_data_in = 0; beat counter = 0.
- States:
  - IDLE: core_reset = 1 for exactly one cycle, then go to LOAD.
  - LOAD: msg_ready = 1. On msg_valid & msg_ready, capture msg_data into blk and msg_last into last_q, set in_msg, go to ABS_GO.
  - ABS_GO: core_start_continue = 1, core_msg_data_available = 1, core_data_in = blk; go to ABS_WAIT.
  - ABS_WAIT: core_busy is ignored in the first cycle. From the second cycle on, when core_busy = 0: if last_q, go to PAD_GO; else go to LOAD.
  - PAD_GO: core_start_continue = 1, core_msg_data_available = 1, core_data_in = {1'b1, (RATE-1)'b0}; go to PAD_WAIT.
  - PAD_WAIT: same first-cycle rule as ABS_WAIT. When core_busy = 0, capture core_data_out into dig_data, clear the counter, go to OUT.
  - OUT: dig_valid = 1, dig_last = (cnt == N-1). On dig_ready:
    - if dig_last, clear in_msg and go to IDLE;
    - else increment cnt and go to SQ_GO.
  - SQ_GO: core_start_continue = 1, core_msg_data_available = 0, core_data_in = 0; go to SQ_WAIT.
  - SQ_WAIT: same first-cycle rule. When core_busy = 0, capture core_data_out into dig_data and go to OUT.
- busy = in_msg OR state not in {IDLE, LOAD}.
- core_start_continue is high for exactly one cycle per core invocation and is never high while core_busy = 1.
- The padding block is always issued, including when the message length is a multiple of RATE. Zero-length messages are not supported.
- Invocation count per message: (#message blocks + 1) absorb starts, then N-1 squeeze starts.
- Latency: a 1-block message with dig_ready = 1 gives the first dig_valid 2 + 2·(1 + Tcore) cycles after acceptance, where Tcore is the core's busy duration.
- Backpressure:
  - dig_data and dig_last are held while dig_valid & !dig_ready.
  - No squeeze is issued before the current beat is accepted.
- msg_valid gaps in LOAD are tolerated indefinitely. msg_ready is 0 in all states other than LOAD.
- Counter width is clog2(N), minimum 1. Behaviour for N = 1: the first beat has dig_last = 1 and no squeeze is issued.
- Reset mid-operation:
  - Next cycle all outputs take reset values and core_reset = 1.
  - A beat in flight is dropped.
  - The partial message is discarded.

Test Plan:
- RATE = 8, DIGEST_BITS = 128, single block 0x61 with last -> core sees absorb 0x61, absorb 0x80, then 15 squeezes. 16 digest beats, dig_last only on beat 16. Digest matches the SPONGENT golden model.
- dig_ready held low for 5 cycles at beat 3 -> dig_data and dig_valid stable throughout, zero core_start_continue pulses in that window.
- 3-block message 0x01, 0x02, 0x03 with 0–4 idle cycles between msg_valid beats -> digest identical to the back-to-back run.
- Core model stretches busy to 40 cycles -> the next start occurs only after busy falls. start_continue & core_busy is never 1 in the same cycle.
- Reset pulsed during SQ_WAIT of beat 7 -> next cycle dig_valid = 0, busy = 0, core_reset = 1. A following 0x61 message yields the correct full digest.
- Two messages back-to-back ("a", then "abc") -> one IDLE cycle with core_reset = 1 between them. Each digest matches the golden model independently.
